// File: rtl/timer_pkg.sv
// Shared types and constants for the mm:ss BCD timer core.
// Latency: n/a (package). Backpressure: n/a.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUN     = 2'd1,
        ST_EXPIRED = 2'd2
    } state_t;

    localparam logic [3:0] DIGIT_MAX    = 4'd9;
    localparam logic [3:0] SEC_TENS_MAX = 4'd5;

    localparam logic MODE_UP   = 1'b0;
    localparam logic MODE_DOWN = 1'b1;

    typedef struct packed {
        logic [3:0] m1;
        logic [3:0] m0;
        logic [3:0] s1;
        logic [3:0] s0;
    } bcd_time_t;

    function automatic logic [3:0] sat_digit(input logic [3:0] d, input logic [3:0] lim);
        return (d > lim) ? lim : d;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Prescaler: one-cycle tick every TICK_CYCLES enabled clocks.
// Latency: first tick TICK_CYCLES-1 cycles after clr. Backpressure: none; en freezes the count.
module tick_gen #(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;
    logic             at_top;

    assign at_top = (cnt_q == CNT_W'(TICK_CYCLES - 1));
    assign tick   = en && at_top;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_top ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/timer_core_bcd.sv
// Stopwatch / countdown mm:ss core driving four BCD digits to the 7-seg decoders.
// Latency: digits registered, first tick TICK_CYCLES cycles after start. Backpressure: none; pulses act on the cycle seen.
module timer_core_bcd
    import timer_pkg::*;
#(
    parameter int TICK_CYCLES = 50_000_000,
    parameter int CNT_W       = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       mode,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       load,
    input  logic [3:0] preset_m1,
    input  logic [3:0] preset_m0,
    input  logic [3:0] preset_s1,
    input  logic [3:0] preset_s0,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic       running,
    output logic       expired,
    output logic       done
);

    state_t    state_q, state_d;
    bcd_time_t time_q, time_d;
    bcd_time_t time_up, time_dn, time_pre;
    logic      mode_q, mode_d;
    logic      done_q, done_d;
    logic      tick;
    logic      load_ok, start_go, run_tick;
    logic      is_zero, at_max, dn_hits_zero;

    assign is_zero      = (time_q == '0);
    assign at_max       = (time_q.m1 == DIGIT_MAX) && (time_q.m0 == DIGIT_MAX) &&
                          (time_q.s1 == SEC_TENS_MAX) && (time_q.s0 == DIGIT_MAX);
    assign dn_hits_zero = (time_dn == '0);

    // Command arbitration: clear beats load beats start_stop; load is dead while running.
    assign load_ok  = !clear && load && (state_q != ST_RUN);
    assign start_go = !clear && !load && start_stop && (state_q == ST_IDLE) &&
                      !((mode == MODE_DOWN) && is_zero);
    assign run_tick = !clear && !start_stop && (state_q == ST_RUN) && tick;

    assign time_pre.m1 = sat_digit(preset_m1, DIGIT_MAX);
    assign time_pre.m0 = sat_digit(preset_m0, DIGIT_MAX);
    assign time_pre.s1 = sat_digit(preset_s1, SEC_TENS_MAX);
    assign time_pre.s0 = sat_digit(preset_s0, DIGIT_MAX);

    tick_gen #(
        .TICK_CYCLES (TICK_CYCLES),
        .CNT_W       (CNT_W)
    ) u_tick_gen (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (state_q == ST_RUN),
        .clr   (clear || start_go),
        .tick  (tick)
    );

    always_comb begin
        time_up = time_q;
        if (time_q.s0 != DIGIT_MAX) begin
            time_up.s0 = time_q.s0 + 4'd1;
        end else begin
            time_up.s0 = '0;
            if (time_q.s1 != SEC_TENS_MAX) begin
                time_up.s1 = time_q.s1 + 4'd1;
            end else begin
                time_up.s1 = '0;
                if (time_q.m0 != DIGIT_MAX) begin
                    time_up.m0 = time_q.m0 + 4'd1;
                end else begin
                    time_up.m0 = '0;
                    time_up.m1 = time_q.m1 + 4'd1;
                end
            end
        end
    end

    always_comb begin
        time_dn = time_q;
        if (time_q.s0 != 4'd0) begin
            time_dn.s0 = time_q.s0 - 4'd1;
        end else begin
            time_dn.s0 = DIGIT_MAX;
            if (time_q.s1 != 4'd0) begin
                time_dn.s1 = time_q.s1 - 4'd1;
            end else begin
                time_dn.s1 = SEC_TENS_MAX;
                if (time_q.m0 != 4'd0) begin
                    time_dn.m0 = time_q.m0 - 4'd1;
                end else begin
                    time_dn.m0 = DIGIT_MAX;
                    time_dn.m1 = time_q.m1 - 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            time_q  <= '0;
            mode_q  <= MODE_UP;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            time_q  <= time_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (clear || load_ok) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE:    if (start_go) state_d = ST_RUN;
                ST_RUN: begin
                    if (start_stop) begin
                        state_d = ST_IDLE;
                    end else if (tick) begin
                        if (mode_q == MODE_UP && at_max) begin
                            state_d = ST_IDLE;
                        end else if (mode_q == MODE_DOWN && dn_hits_zero) begin
                            state_d = ST_EXPIRED;
                        end
                    end
                end
                ST_EXPIRED: state_d = ST_EXPIRED;
                default:    state_d = ST_IDLE;
            endcase
        end
    end

    always_comb begin
        time_d = time_q;
        mode_d = mode_q;
        done_d = 1'b0;
        if (clear) begin
            time_d = '0;
        end else if (load_ok) begin
            time_d = time_pre;
        end else if (start_go) begin
            mode_d = mode;
        end else if (run_tick) begin
            // At 99:59 the up count holds rather than wrapping.
            if (mode_q == MODE_UP) begin
                if (!at_max) time_d = time_up;
            end else begin
                time_d = time_dn;
                done_d = dn_hits_zero;
            end
        end
    end

    always_comb begin
        running = (state_q == ST_RUN);
        expired = (state_q == ST_EXPIRED);
    end

    assign done = done_q;
    assign m1   = time_q.m1;
    assign m0   = time_q.m0;
    assign s1   = time_q.s1;
    assign s0   = time_q.s0;

endmodule

// File: tb/tb_timer_core_bcd.sv
// Directed bench for timer_core_bcd with TICK_CYCLES=4: vector table plus multi-cycle sequences.
module tb_timer_core_bcd;

    logic       clk;
    logic       rst_n;
    logic       mode, start_stop, clear, load;
    logic [3:0] preset_m1, preset_m0, preset_s1, preset_s0;
    logic [3:0] m1, m0, s1, s0;
    logic       running, expired, done;

    int total = 0;
    int bad   = 0;
    int done_cnt = 0;
    int done_base;

    timer_core_bcd #(.TICK_CYCLES(4), .CNT_W(3)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .mode       (mode),
        .start_stop (start_stop),
        .clear      (clear),
        .load       (load),
        .preset_m1  (preset_m1),
        .preset_m0  (preset_m0),
        .preset_s1  (preset_s1),
        .preset_s0  (preset_s0),
        .m1         (m1),
        .m0         (m0),
        .s1         (s1),
        .s0         (s0),
        .running    (running),
        .expired    (expired),
        .done       (done)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    typedef struct {
        logic        c, l, s, md;
        logic [15:0] pre;
        logic [15:0] exp_t;
        logic        exp_run, exp_exp, exp_done;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic chk_state(input string nm, input logic [15:0] t, input logic r, input logic e);
        chk({nm, ".digits"}, {16'h0, m1, m0, s1, s0}, {16'h0, t});
        chk({nm, ".running"}, {31'h0, running}, {31'h0, r});
        chk({nm, ".expired"}, {31'h0, expired}, {31'h0, e});
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic set_pre(input logic [15:0] p);
        {preset_m1, preset_m0, preset_s1, preset_s0} = p;
    endtask

    task automatic pulse(input logic c, input logic l, input logic s);
        clear = c; load = l; start_stop = s;
        cyc(1);
        clear = 1'b0; load = 1'b0; start_stop = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; mode = 1'b0; start_stop = 1'b0; clear = 1'b0; load = 1'b0;
        set_pre(16'h0);

        // c l s md  preset   digits  run exp done
        vecs[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h7C8F, 16'h7959, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b1, 16'h0003, 16'h0003, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 1'b1, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b1, 1'b0, 1'b0, 16'h1234, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0003, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0002, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 16'h0000, 16'h0002, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0};

        cyc(2);
        chk_state("reset", 16'h0000, 1'b0, 1'b0);
        chk("reset.done", {31'h0, done}, 32'h0);
        rst_n = 1'b1;
        cyc(1);

        for (int i = 0; i < 11; i++) begin
            mode = vecs[i].md;
            set_pre(vecs[i].pre);
            pulse(vecs[i].c, vecs[i].l, vecs[i].s);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_t, vecs[i].exp_run, vecs[i].exp_exp);
            chk($sformatf("vec%0d.done", i), {31'h0, done}, {31'h0, vecs[i].exp_done});
        end

        // Stopwatch carry through 09:59 -> 10:00 -> 10:01
        mode = 1'b0; set_pre(16'h0958);
        pulse(1'b0, 1'b1, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(4); chk_state("up.t1", 16'h0959, 1'b1, 1'b0);
        cyc(4); chk_state("up.t2", 16'h1000, 1'b1, 1'b0);
        cyc(4); chk_state("up.t3", 16'h1001, 1'b1, 1'b0);
        pulse(1'b1, 1'b0, 1'b0);

        // Countdown 01:00 to expiry
        mode = 1'b1; set_pre(16'h0100);
        pulse(1'b0, 1'b1, 1'b0);
        done_base = done_cnt;
        pulse(1'b0, 1'b0, 1'b1);
        cyc(4);   chk_state("dn.t1", 16'h0059, 1'b1, 1'b0);
        cyc(235); chk_state("dn.pre", 16'h0001, 1'b1, 1'b0);
        chk("dn.pre.done", {31'h0, done}, 32'h0);
        cyc(1);   chk_state("dn.zero", 16'h0000, 1'b0, 1'b1);
        chk("dn.zero.done", {31'h0, done}, 32'h1);
        cyc(1);   chk("dn.after.done", {31'h0, done}, 32'h0);
        chk("dn.done_pulses", done_cnt - done_base, 32'd1);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(2);   chk_state("dn.ss_ignored", 16'h0000, 1'b0, 1'b1);
        set_pre(16'h0005);
        pulse(1'b0, 1'b1, 1'b0);
        chk_state("exp.load", 16'h0005, 1'b0, 1'b0);

        // Reset mid-run
        pulse(1'b0, 1'b0, 1'b1);
        cyc(5);   chk_state("rst.mid", 16'h0004, 1'b1, 1'b0);
        rst_n = 1'b0;
        cyc(1);   chk_state("rst.edge1", 16'h0000, 1'b0, 1'b0);
        chk("rst.edge1.done", {31'h0, done}, 32'h0);
        cyc(1);
        rst_n = 1'b1;
        cyc(1);   chk_state("rst.after", 16'h0000, 1'b0, 1'b0);

        // Saturation at 99:59
        mode = 1'b0; set_pre(16'h9958);
        pulse(1'b0, 1'b1, 1'b0);
        done_base = done_cnt;
        pulse(1'b0, 1'b0, 1'b1);
        cyc(8);   chk_state("sat.t2", 16'h9959, 1'b0, 1'b0);
        cyc(40);  chk_state("sat.hold", 16'h9959, 1'b0, 1'b0);
        chk("sat.no_done", done_cnt - done_base, 32'd0);

        // Pause / resume timing
        pulse(1'b1, 1'b0, 1'b0);
        mode = 1'b0;
        pulse(1'b0, 1'b0, 1'b1);
        cyc(4);   chk_state("pause.t1", 16'h0001, 1'b1, 1'b0);
        cyc(2);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(20);  chk_state("pause.frozen", 16'h0001, 1'b0, 1'b0);
        pulse(1'b0, 1'b0, 1'b1);
        cyc(3);   chk_state("resume.pre", 16'h0001, 1'b1, 1'b0);
        cyc(1);   chk_state("resume.tick", 16'h0002, 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
